// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory access unit: request size codes,
// the sequencing state encoding and the alignment rule applied at accept.
// Optional feature macro used by the unit: LSU_SUBWORD_EN.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    // True when the size code is reserved or the address is not naturally aligned
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundle of the pipeline request/response signals and the word-wide data
// memory bus. The master modport is the access unit; the slave modport is
// the environment (pipeline driving requests, memory returning ReadData).
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high; req_ready is high only while the unit is idle.
// resp_valid is a single-cycle pulse with no backpressure, and err/resp_rdata
// are meaningful only in that cycle.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        err;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    modport master (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, ReadData,
        output req_ready, resp_valid, resp_rdata, err, MemRead, MemWrite, Address, WriteData
    );

    modport slave (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, ReadData,
        input  req_ready, resp_valid, resp_rdata, err, MemRead, MemWrite, Address, WriteData
    );
endinterface

// File: rtl/lsu_align.sv
// Little-endian lane handling for a word-only memory: extracts a byte or
// halfword from a read word with sign/zero extension, and merges store data
// into the selected lane of an old word for read-modify-write.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);
    logic [4:0]  byte_shift;
    logic [4:0]  half_shift;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    logic        unused_wdata;

    // Halfword lanes are chosen by addr[1] alone; addr[0] is rejected upstream
    assign byte_shift   = {addr_lo, 3'b000};
    assign half_shift   = {addr_lo[1], 4'b0000};
    assign unused_wdata = &{1'b0, wdata[31:16]};

    // Load path: select the addressed lane and extend it to 32 bits
    always_comb begin
        lane_b = 8'(rdata >> byte_shift);
        lane_h = 16'(rdata >> half_shift);
        case (size)
            SZ_BYTE: load_data = {{24{sign_ext & lane_b[7]}}, lane_b};
            SZ_HALF: load_data = {{16{sign_ext & lane_h[15]}}, lane_h};
            default: load_data = rdata;
        endcase
    end

    // Store path: replace only the addressed lane of the old word
    always_comb begin
        case (size)
            SZ_BYTE: begin
                lane_mask = 32'h0000_00FF << byte_shift;
                lane_data = {24'd0, wdata[7:0]} << byte_shift;
            end
            SZ_HALF: begin
                lane_mask = 32'h0000_FFFF << half_shift;
                lane_data = {16'd0, wdata[15:0]} << half_shift;
            end
            default: begin
                lane_mask = 32'hFFFF_FFFF;
                lane_data = wdata;
            end
        endcase
        merge_data = (rdata & ~lane_mask) | (lane_data & lane_mask);
    end
endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the word-addressed data memory. Takes one load/store at a
// time, drives registered MemRead/MemWrite strobes and returns a one-cycle
// response. Optional macro LSU_SUBWORD_EN enables byte/halfword accesses
// (loads by lane extraction, stores by read-modify-write); without it only
// word accesses are legal and smaller sizes complete with err.
module mem_access_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    mem_access_unit_if.master bus,
    output state_t            dbg_state
);
    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

    state_t      state;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        size_ok;
    logic        use_rmw;
    logic        acc_err;
    logic        unused_regs;

`ifdef LSU_SUBWORD_EN
    logic [31:0] rd_result;
    logic [31:0] wr_merged;

    assign size_ok     = (bus.req_size != 2'b11);
    assign use_rmw     = (bus.req_size != SZ_WORD);
    assign unused_regs = &{1'b0, r_addr[31:2]};

    lsu_align u_align (
        .rdata      (bus.ReadData),
        .addr_lo    (r_addr[1:0]),
        .size       (r_size),
        .sign_ext   (r_signed),
        .wdata      (r_wdata),
        .load_data  (rd_result),
        .merge_data (wr_merged)
    );
`else
    assign size_ok     = (bus.req_size == SZ_WORD);
    assign use_rmw     = 1'b0;
    assign unused_regs = &{1'b0, r_write, r_size, r_signed, r_addr, r_wdata};
`endif

    assign acc_err       = !size_ok
                         || misaligned(bus.req_size, bus.req_addr[1:0])
                         || (bus.req_addr >= ADDR_LIMIT);
    assign bus.req_ready = (state == IDLE);
    assign dbg_state     = state;

    // Request sequencing: accept, strobe the memory once, pulse the response
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            r_write        <= 1'b0;
            r_size         <= 2'b00;
            r_signed       <= 1'b0;
            r_addr         <= 32'd0;
            r_wdata        <= 32'd0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 32'd0;
            bus.err        <= 1'b0;
            bus.MemRead    <= 1'b0;
            bus.MemWrite   <= 1'b0;
            bus.Address    <= 32'd0;
            bus.WriteData  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_write  <= bus.req_write;
                        r_size   <= bus.req_size;
                        r_signed <= bus.req_signed;
                        r_addr   <= bus.req_addr;
                        r_wdata  <= bus.req_wdata;
                        if (acc_err) begin
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.err        <= 1'b1;
                            bus.resp_rdata <= 32'd0;
                        end else begin
                            bus.Address <= {bus.req_addr[31:2], 2'b00};
                            if (!bus.req_write || use_rmw) begin
                                state       <= RD;
                                bus.MemRead <= 1'b1;
                            end else begin
                                state         <= WR;
                                bus.MemWrite  <= 1'b1;
                                bus.WriteData <= bus.req_wdata;
                            end
                        end
                    end
                end
                RD: begin
                    bus.MemRead <= 1'b0;
`ifdef LSU_SUBWORD_EN
                    if (r_write) begin
                        state         <= WR;
                        bus.MemWrite  <= 1'b1;
                        bus.WriteData <= wr_merged;
                    end else begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.err        <= 1'b0;
                        bus.resp_rdata <= rd_result;
                    end
`else
                    state          <= RESP;
                    bus.resp_valid <= 1'b1;
                    bus.err        <= 1'b0;
                    bus.resp_rdata <= bus.ReadData;
`endif
                end
                WR: begin
                    bus.MemWrite   <= 1'b0;
                    state          <= RESP;
                    bus.resp_valid <= 1'b1;
                    bus.err        <= 1'b0;
                    bus.resp_rdata <= 32'd0;
                end
                RESP: begin
                    bus.resp_valid <= 1'b0;
                    bus.err        <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a memory model on the bus, a request driver, a
// reference model of load/store results over its own copy of memory, and a
// monitor that checks every response, strobe and write against expectations.
module tb_mem_access_unit;
    import lsu_pkg::*;

    localparam int MEM_WORDS = 1024;
    localparam int W = 41;  // {rd_cnt[2], wr_cnt[2], latency[4], err, rdata[32]}

    logic   clk = 1'b0;
    logic   reset = 1'b1;
    state_t dbg_state;
    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;

    mem_access_unit_if bus();

    mem_access_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- memory model ----------------
    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    bit          mem_load = 1'b1;

    assign bus.ReadData = mem[int'(bus.Address[31:2]) % MEM_WORDS];

    always @(negedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= ref_mem[i];
        end else if (bus.MemWrite) begin
            mem[int'(bus.Address[31:2]) % MEM_WORDS] <= bus.WriteData;
        end
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q [$];
    int           acc_q [$];
    logic [31:0]  wd_q  [$];
    logic [31:0]  cur_addr = 32'd0;
    int           rd_seen = 0;
    int           wr_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            rd_seen = 0;
            wr_seen = 0;
        end
    end

    // Monitor: strobe legality, write data, and response comparison
    always @(negedge clk) begin
        logic [W-1:0] e;
        int a0;
        if (!reset) begin
            if (bus.MemRead && bus.MemWrite)
                check("strobe_overlap", 32'd1, 32'd0);
            if (bus.MemRead || bus.MemWrite)
                check("address", bus.Address, cur_addr);
            if (bus.MemRead) rd_seen++;
            if (bus.MemWrite) begin
                wr_seen++;
                if (wd_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
                else check("write_data", bus.WriteData, wd_q.pop_front());
            end
            if (bus.resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e  = exp_q.pop_front();
                    a0 = acc_q.pop_front();
                    check("resp_err", 32'(bus.err), 32'(e[32]));
                    check("resp_rdata", bus.resp_rdata, e[31:0]);
                    check("latency", 32'(cyc - a0), 32'(e[36:33]));
                    check("read_strobes", 32'(rd_seen), 32'(e[40:39]));
                    check("write_strobes", 32'(wr_seen), 32'(e[38:37]));
                end
                rd_seen = 0;
                wr_seen = 0;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic bit model_err(input logic [1:0] sz, input logic [31:0] a);
        bit bad;
        bad = 1'b0;
        if (sz == 2'b11) bad = 1'b1;
`ifndef LSU_SUBWORD_EN
        if (sz != 2'b10) bad = 1'b1;
`endif
        if (sz == 2'b01 && (a % 2) != 0) bad = 1'b1;
        if (sz == 2'b10 && (a % 4) != 0) bad = 1'b1;
        if (a >= 32'(MEM_WORDS * 4)) bad = 1'b1;
        return bad;
    endfunction

    // ---------------- driver ----------------
    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input bit keep, input bit abort);
        logic [W-1:0] e;
        logic [31:0]  word, mask, val, newword;
        int           sh, nb;
        bit           bad, accepted;
        bad     = model_err(sz, a);
        newword = 32'd0;
        if (bad) begin
            e = {2'd0, 2'd0, 4'd1, 1'b1, 32'd0};
        end else begin
            word = ref_mem[a / 4];
            sh   = 8 * int'(a % 4);
            nb   = (sz == 2'b10) ? 4 : ((sz == 2'b01) ? 2 : 1);
            mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
            if (!wr) begin
                val = (word >> sh) & mask;
                if (sg && nb < 4 && val[8 * nb - 1]) val = val | ~mask;
                e = {2'd1, 2'd0, 4'd2, 1'b0, val};
            end else begin
                newword = (word & ~(mask << sh)) | ((wd & mask) << sh);
                if (nb == 4) e = {2'd0, 2'd1, 4'd2, 1'b0, 32'd0};
                else         e = {2'd1, 2'd1, 4'd3, 1'b0, 32'd0};
            end
        end
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        accepted = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.req_ready) begin
                @(posedge clk);
                accepted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!accepted) begin
            check("accept_timeout", 32'd1, 32'd0);
            bus.req_valid = 1'b0;
        end else begin
            check("accept_while_busy", 32'(exp_q.size()), 32'd0);
            cur_addr = {a[31:2], 2'b00};
            if (!abort) begin
                exp_q.push_back(e);
                acc_q.push_back(cyc);
                if (wr && !bad) begin
                    wd_q.push_back(newword);
                    ref_mem[a / 4] = newword;
                end
            end
            if (!keep) begin
                #1;
                bus.req_valid = 1'b0;
            end
        end
    endtask

    task automatic wait_resp();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("resp_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            acc_q.delete();
            wd_q.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = $urandom;
        ref_mem[4]     = 32'h8899_AABB;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        reset = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_memread", 32'(bus.MemRead), 32'd0);
        check("rst_memwrite", 32'(bus.MemWrite), 32'd0);
        check("rst_address", bus.Address, 32'd0);
        check("rst_writedata", bus.WriteData, 32'd0);
        mem_load = 1'b0;
        reset    = 1'b0;

        // word load of the preloaded word
        issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, 0, 0); wait_resp();
        // sub-word loads, signed and unsigned
        issue(1'b0, SZ_BYTE, 1'b1, 32'h13, 32'd0, 0, 0); wait_resp();
        issue(1'b0, SZ_BYTE, 1'b0, 32'h13, 32'd0, 0, 0); wait_resp();
        issue(1'b0, SZ_HALF, 1'b1, 32'h12, 32'd0, 0, 0); wait_resp();
        issue(1'b0, SZ_HALF, 1'b0, 32'h10, 32'd0, 0, 0); wait_resp();
        // byte store as read-modify-write, read back, then a word store
        issue(1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h1234_56CC, 0, 0); wait_resp();
        issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, 0, 0); wait_resp();
        issue(1'b1, SZ_WORD, 1'b0, 32'h14, 32'hCAFE_F00D, 0, 0); wait_resp();
        issue(1'b1, SZ_HALF, 1'b0, 32'h16, 32'hFFFF_5A5A, 0, 0); wait_resp();
        issue(1'b0, SZ_WORD, 1'b0, 32'h14, 32'd0, 0, 0); wait_resp();
        // error cases: misaligned, reserved size, out of range
        issue(1'b0, SZ_HALF, 1'b0, 32'h11, 32'd0, 0, 0); wait_resp();
        issue(1'b0, SZ_WORD, 1'b0, 32'h12, 32'd0, 0, 0); wait_resp();
        issue(1'b0, 2'b11,   1'b0, 32'h10, 32'd0, 0, 0); wait_resp();
        issue(1'b0, SZ_WORD, 1'b0, 32'h1000, 32'd0, 0, 0); wait_resp();
        issue(1'b1, SZ_WORD, 1'b0, 32'h1004, 32'h1111_2222, 0, 0); wait_resp();
        // back-to-back with req_valid held high
        issue(1'b1, SZ_BYTE, 1'b0, 32'h12, 32'h0000_0042, 1, 0);
        issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, 1, 0);
        issue(1'b1, SZ_WORD, 1'b0, 32'h18, 32'h0BAD_BEEF, 0, 0);
        wait_resp();

        // reset while the request sits in RD: no write, no response
`ifdef LSU_SUBWORD_EN
        issue(1'b1, SZ_BYTE, 1'b0, 32'h10, 32'h0000_0077, 0, 1);
`else
        issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, 0, 1);
`endif
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("post_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("post_rst_memwrite", 32'(bus.MemWrite), 32'd0);
        repeat (4) @(negedge clk);
        check("mem_after_abort", mem[4], ref_mem[4]);
        issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, 0, 0); wait_resp();

        // randomized traffic
        for (int i = 0; i < 80; i++) begin
            bit keep;
            case ($urandom_range(0, 7))
                0:       a = 32'(MEM_WORDS * 4) + 32'($urandom_range(0, 64));
                1:       a = $urandom;
                default: a = 32'($urandom_range(0, 31));
            endcase
            keep = (i < 79) && ($urandom_range(0, 2) == 0);
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  a, $urandom, keep, 0);
            if (!keep) wait_resp();
        end
        wait_resp();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) check("final_mem", mem[i], ref_mem[i]);
        check("leftover_expected", 32'(exp_q.size() + wd_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
